multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle decoder. It produces the same datapath control fields and adds sequencing: a `stall` output for variable-latency memory, two-phase read-modify-write for SB/SH, and a background multiply/divide timer with hazard interlock on HI/LO. It sits between instruction fetch and the datapath. `stall` freezes the PC and the instruction register.

---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control_muldiv_timer.sv | 37 +++
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Contents: opcode/funct/rt codes, RegDst/MemtoReg/RegWrite encodings,
// the sequencing state enum and a small helper used for counter sizing.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LWL    = 6'h22;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_LWR    = 6'h26;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [2:0] M2R_ALU  = 3'd0;
  localparam logic [2:0] M2R_MEM  = 3'd1;
  localparam logic [2:0] M2R_LINK = 3'd2;
  localparam logic [2:0] M2R_HI   = 3'd3;
  localparam logic [2:0] M2R_LO   = 3'd4;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_LWL  = 2'b01;
  localparam logic [1:0] RW_LWR  = 2'b10;
  localparam logic [1:0] RW_WORD = 2'b11;

  typedef enum logic [1:0] {RUN, MEM_WAIT, RMW_WR} state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/memory handshake and datapath control bundle.
// master: instruction source + datapath (drives instruction fields and
//         mem_ready, receives control).
// slave : the control unit.
interface multicycle_control_if;
  logic       instr_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       mem_ready;
  logic       stall;
  logic       JR;
  logic       Jump;
  logic       delay_early;
  logic [1:0] RegWrite;
  logic [1:0] RegDst;
  logic [2:0] MemtoReg;
  logic       MemRead;
  logic       MemWrite;
  logic [1:0] HI_write;
  logic [1:0] LO_write;
  logic       muldiv_start;
  logic       muldiv_is_div;
  logic       muldiv_busy;

  modport master (
    output instr_valid, opcode, funct, rt, mem_ready,
    input  stall, JR, Jump, delay_early, RegWrite, RegDst, MemtoReg,
           MemRead, MemWrite, HI_write, LO_write,
           muldiv_start, muldiv_is_div, muldiv_busy
  );

  modport slave (
    input  instr_valid, opcode, funct, rt, mem_ready,
    output stall, JR, Jump, delay_early, RegWrite, RegDst, MemtoReg,
           MemRead, MemWrite, HI_write, LO_write,
           muldiv_start, muldiv_is_div, muldiv_busy
  );
endinterface

// File: rtl/multicycle_control_muldiv_timer.sv
// Background latency timer for the multiply/divide unit.
// Ports: clk, reset_n (sync, active low), start (load), is_div (selects
// DIV_CYCLES vs MULT_CYCLES), busy (count != 0), done (count == 1).
module muldiv_timer #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);
  import cpu_ctrl_pkg::*;

  localparam int CW = $clog2(max2(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= is_div ? DIV_LOAD : MULT_LOAD;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);
  // Terminal count: the last busy cycle is the HI/LO completion write.
  assign done = (count == CW'(1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: combinational decode of the presented
// instruction plus memory sequencing and HI/LO interlock.
// Ports: clk, reset_n (sync, active low), bus (slave side of
// multicycle_control_if: instruction fields and mem_ready in, stall and
// datapath control out).
//
// state    | meaning
// RUN      | first cycle of an instruction / no memory access pending
// MEM_WAIT | load or word store waiting for mem_ready
// RMW_WR   | write phase of an SB/SH read-modify-write
module multicycle_control #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int RMW_ENABLE  = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  multicycle_control_if.slave  bus
);
  import cpu_ctrl_pkg::*;

  state_t state, state_nx;

  logic valid, rtype;
  logic fn_jr, fn_jalr, fn_mfhi, fn_mflo, fn_mthi, fn_mtlo, fn_muldiv, fn_div;
  logic is_load, is_sbsh, is_wr_op, is_rmw, hazard;
  logic stall, retire, mem_rd, mem_wr;
  logic timer_busy, timer_done;
  logic [1:0] dec_rw, dec_rd;
  logic [2:0] dec_m2r;
  logic dec_jr, dec_jmp, dec_de;

  assign valid     = bus.instr_valid;
  assign rtype     = valid && (bus.opcode == OP_RTYPE);
  assign fn_jr     = rtype && (bus.funct == FN_JR);
  assign fn_jalr   = rtype && (bus.funct == FN_JALR);
  assign fn_mfhi   = rtype && (bus.funct == FN_MFHI);
  assign fn_mflo   = rtype && (bus.funct == FN_MFLO);
  assign fn_mthi   = rtype && (bus.funct == FN_MTHI);
  assign fn_mtlo   = rtype && (bus.funct == FN_MTLO);
  assign fn_div    = rtype && ((bus.funct == FN_DIV) || (bus.funct == FN_DIVU));
  assign fn_muldiv = fn_div || (rtype && ((bus.funct == FN_MULT) || (bus.funct == FN_MULTU)));

  assign is_load  = valid && ((bus.opcode == OP_LB)  || (bus.opcode == OP_LH)  ||
                              (bus.opcode == OP_LW)  || (bus.opcode == OP_LBU) ||
                              (bus.opcode == OP_LHU) || (bus.opcode == OP_LWL) ||
                              (bus.opcode == OP_LWR));
  assign is_sbsh  = valid && ((bus.opcode == OP_SB) || (bus.opcode == OP_SH));
  assign is_rmw   = is_sbsh && (RMW_ENABLE != 0);
  assign is_wr_op = (valid && (bus.opcode == OP_SW)) || (is_sbsh && (RMW_ENABLE == 0));
  assign hazard   = timer_busy && (fn_mfhi || fn_mflo || fn_mthi || fn_mtlo || fn_muldiv);

  always_comb begin
    dec_rw  = RW_NONE;
    dec_rd  = REGDST_RT;
    dec_m2r = M2R_ALU;
    dec_jr  = 1'b0;
    dec_jmp = 1'b0;
    dec_de  = 1'b0;
    if (valid) begin
      case (bus.opcode)
        OP_RTYPE: begin
          if (!(fn_jr || fn_mthi || fn_mtlo || fn_muldiv)) begin
            dec_rw = RW_WORD;
            dec_rd = REGDST_RD;
          end
          if (fn_jr || fn_jalr) begin
            dec_jr = 1'b1;
            dec_de = 1'b1;
          end
          if (fn_jalr) dec_m2r = M2R_LINK;
          if (fn_mfhi) dec_m2r = M2R_HI;
          if (fn_mflo) dec_m2r = M2R_LO;
        end
        OP_REGIMM: begin
          dec_de = 1'b1;
          if ((bus.rt == RT_BLTZAL) || (bus.rt == RT_BGEZAL)) begin
            dec_rd  = REGDST_RA;
            dec_m2r = M2R_LINK;
            dec_rw  = RW_WORD;
          end
        end
        OP_J: begin
          dec_jmp = 1'b1;
          dec_de  = 1'b1;
        end
        OP_JAL: begin
          dec_jmp = 1'b1;
          dec_de  = 1'b1;
          dec_rd  = REGDST_RA;
          dec_m2r = M2R_LINK;
          dec_rw  = RW_WORD;
        end
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: dec_de = 1'b1;
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
          dec_m2r = M2R_MEM;
          dec_rw  = RW_WORD;
        end
        OP_LWL: begin
          dec_m2r = M2R_MEM;
          dec_rw  = RW_LWL;
        end
        OP_LWR: begin
          dec_m2r = M2R_MEM;
          dec_rw  = RW_LWR;
        end
        OP_SB, OP_SH, OP_SW: ;
        default: dec_rw = RW_WORD;
      endcase
    end
  end

  // Strobes stay asserted for the whole phase so memory sees the request
  // in every cycle it is waiting on.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    if (!valid) begin
      state_nx = RUN;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            stall = 1'b1;
          end else if (is_load || is_wr_op) begin
            mem_rd = is_load;
            mem_wr = is_wr_op;
            stall  = !bus.mem_ready;
            if (!bus.mem_ready) state_nx = MEM_WAIT;
          end else if (is_rmw) begin
            mem_rd = 1'b1;
            stall  = 1'b1;
            if (bus.mem_ready) state_nx = RMW_WR;
          end
        end
        MEM_WAIT: begin
          mem_rd = is_load;
          mem_wr = is_wr_op;
          stall  = !bus.mem_ready;
          if (bus.mem_ready) state_nx = RUN;
        end
        RMW_WR: begin
          mem_wr = 1'b1;
          stall  = !bus.mem_ready;
          if (bus.mem_ready) state_nx = RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nx;
  end

  assign retire = valid && !stall;

  muldiv_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (retire && fn_muldiv),
    .is_div  (fn_div),
    .busy    (timer_busy),
    .done    (timer_done)
  );

  // Every output is forced low while reset is asserted.
  assign bus.stall         = reset_n && stall;
  assign bus.JR            = reset_n && retire && dec_jr;
  assign bus.Jump          = reset_n && retire && dec_jmp;
  assign bus.delay_early   = reset_n && retire && dec_de;
  assign bus.RegWrite      = (reset_n && retire) ? dec_rw : RW_NONE;
  assign bus.RegDst        = reset_n ? dec_rd : REGDST_RT;
  assign bus.MemtoReg      = reset_n ? dec_m2r : M2R_ALU;
  assign bus.MemRead       = reset_n && mem_rd;
  assign bus.MemWrite      = reset_n && mem_wr;
  assign bus.HI_write      = (reset_n && (timer_done || (retire && fn_mthi))) ? 2'b11 : 2'b00;
  assign bus.LO_write      = (reset_n && (timer_done || (retire && fn_mtlo))) ? 2'b11 : 2'b00;
  assign bus.muldiv_start  = reset_n && retire && fn_muldiv;
  assign bus.muldiv_is_div = reset_n && retire && fn_div;
  assign bus.muldiv_busy   = reset_n && timer_busy;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       v     = 1'b0;
  logic       rdy   = 1'b0;
  logic [5:0] op    = 6'h00;
  logic [5:0] fn    = 6'h00;
  logic [4:0] r     = 5'h00;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_if ifa ();
  multicycle_control_if ifb ();

  assign ifa.instr_valid = v;
  assign ifa.opcode      = op;
  assign ifa.funct       = fn;
  assign ifa.rt          = r;
  assign ifa.mem_ready   = rdy;
  assign ifb.instr_valid = v;
  assign ifb.opcode      = op;
  assign ifb.funct       = fn;
  assign ifb.rt          = r;
  assign ifb.mem_ready   = rdy;

  multicycle_control #(.MULT_CYCLES(4), .DIV_CYCLES(32), .RMW_ENABLE(1)) dut_a (
    .clk(clk), .reset_n(rst_n), .bus(ifa));
  multicycle_control #(.MULT_CYCLES(1), .DIV_CYCLES(3), .RMW_ENABLE(0)) dut_b (
    .clk(clk), .reset_n(rst_n), .bus(ifb));

  wire [19:0] act_a = {ifa.stall, ifa.JR, ifa.Jump, ifa.delay_early, ifa.RegWrite,
                       ifa.RegDst, ifa.MemtoReg, ifa.MemRead, ifa.MemWrite,
                       ifa.HI_write, ifa.LO_write, ifa.muldiv_start,
                       ifa.muldiv_is_div, ifa.muldiv_busy};
  wire [19:0] act_b = {ifb.stall, ifb.JR, ifb.Jump, ifb.delay_early, ifb.RegWrite,
                       ifb.RegDst, ifb.MemtoReg, ifb.MemRead, ifb.MemWrite,
                       ifb.HI_write, ifb.LO_write, ifb.muldiv_start,
                       ifb.muldiv_is_div, ifb.muldiv_busy};

  // Reference model: per instance, a cycle index at which HI/LO becomes
  // free and the number of memory acknowledges already taken by the
  // current SB/SH.
  int cyc_n = 0;
  int end_cyc [2] = '{-100, -100};
  int phase   [2] = '{0, 0};

  function automatic int mlen(input int k); return (k == 0) ? 4 : 1; endfunction
  function automatic int dlen(input int k); return (k == 0) ? 32 : 3; endfunction
  function automatic bit rmw_en(input int k); return (k == 0); endfunction

  function automatic bit is_rmw(input int k);
    return v && (op == 6'h28 || op == 6'h29) && rmw_en(k);
  endfunction

  function automatic logic [19:0] model(input int k);
    logic [1:0] rw, rd;
    logic [2:0] m2r;
    logic jr, jp, de, ld, stw, rmw, hilo, mthi, mtlo, md, dv;
    logic st, ret, busy, done, mrd, mwr;
    rw = 2'd0; rd = 2'd0; m2r = 3'd0;
    jr = 0; jp = 0; de = 0; ld = 0; stw = 0; rmw = 0;
    hilo = 0; mthi = 0; mtlo = 0; md = 0; dv = 0;
    if (!rst_n) return 20'h0;
    if (v) begin
      if (op == 6'h00) begin
        hilo = fn inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
        md   = fn inside {6'h18, 6'h19, 6'h1A, 6'h1B};
        dv   = fn inside {6'h1A, 6'h1B};
        mthi = (fn == 6'h11);
        mtlo = (fn == 6'h13);
        if (!(fn inside {6'h08, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B})) begin
          rw = 2'd3; rd = 2'd1;
        end
        if (fn == 6'h08 || fn == 6'h09) begin jr = 1; de = 1; end
        m2r = (fn == 6'h09) ? 3'd2 : (fn == 6'h10) ? 3'd3 : (fn == 6'h12) ? 3'd4 : 3'd0;
      end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
        ld = 1; m2r = 3'd1; rw = 2'd3;
      end else if (op == 6'h22) begin
        ld = 1; m2r = 3'd1; rw = 2'd1;
      end else if (op == 6'h26) begin
        ld = 1; m2r = 3'd1; rw = 2'd2;
      end else if (op == 6'h2B || (op inside {6'h28, 6'h29} && !rmw_en(k))) begin
        stw = 1;
      end else if (op inside {6'h28, 6'h29}) begin
        rmw = 1;
      end else if (op == 6'h02 || op == 6'h03) begin
        jp = 1; de = 1;
        if (op == 6'h03) begin rd = 2'd2; m2r = 3'd2; rw = 2'd3; end
      end else if (op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) begin
        de = 1;
        if (op == 6'h01 && (r == 5'h10 || r == 5'h11)) begin
          rd = 2'd2; m2r = 3'd2; rw = 2'd3;
        end
      end else begin
        rw = 2'd3;
      end
    end
    busy = (cyc_n <= end_cyc[k]);
    done = (cyc_n == end_cyc[k]);
    if (!v)                st = 0;
    else if (hilo && busy) st = 1;
    else if (ld || stw)    st = !rdy;
    else if (rmw)          st = (phase[k] == 0) ? 1'b1 : !rdy;
    else                   st = 0;
    ret = v && !st;
    mrd = ld || (rmw && phase[k] == 0);
    mwr = stw || (rmw && phase[k] == 1);
    return {st, ret & jr, ret & jp, ret & de, ret ? rw : 2'b00, rd, m2r, mrd, mwr,
            (done || (ret && mthi)) ? 2'b11 : 2'b00,
            (done || (ret && mtlo)) ? 2'b11 : 2'b00,
            ret & md, ret & md & dv, busy};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [19:0] e;
      e = model(k);
      if (!rst_n) begin
        phase[k]   = 0;
        end_cyc[k] = -100;
      end else begin
        if (e[2]) end_cyc[k] = cyc_n + (e[1] ? dlen(k) : mlen(k));
        if (!v) phase[k] = 0;
        else if (is_rmw(k) && rdy) phase[k] = (phase[k] == 0) ? 1 : 0;
      end
    end
    cyc_n++;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [19:0] e, a;
      e = model(k);
      a = (k == 0) ? act_a : act_b;
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL cycle_cmp dut%0d cycle %0d: got %05h expected %05h", k, cyc_n, a, e);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic vv, input logic [5:0] o,
                      input logic [5:0] f, input logic [4:0] rr, input logic rd_);
    @(posedge clk);
    #1;
    rst_n = rn; v = vv; op = o; fn = f; r = rr; rdy = rd_;
    @(negedge clk);
  endtask

  task automatic ins(input logic [5:0] o, input logic [5:0] f, input logic [4:0] rr,
                     input logic rd_);
    step(1'b1, 1'b1, o, f, rr, rd_);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 6'h00, 6'h00, 5'h00, 1'b0);
  endtask

  initial begin
    int stalls;
    int hi_last;
    rst_n = 1'b0; v = 1'b1; op = 6'h23; fn = 6'h00; r = 5'h00; rdy = 1'b1;

    step(1'b0, 1'b1, 6'h23, 6'h00, 5'h00, 1'b1);
    step(1'b0, 1'b1, 6'h23, 6'h00, 5'h00, 1'b1);
    chk("rst_outputs_a", int'(act_a), 0);
    chk("rst_outputs_b", int'(act_b), 0);

    ins(6'h23, 6'h00, 5'h00, 1'b1);
    chk("lw_memread", int'(ifa.MemRead), 1);
    chk("lw_regwrite", int'(ifa.RegWrite), 3);
    chk("lw_memtoreg", int'(ifa.MemtoReg), 1);
    chk("lw_stall", int'(ifa.stall), 0);

    for (int i = 0; i < 3; i++) begin
      ins(6'h23, 6'h00, 5'h00, 1'b0);
      chk("lw_wait_stall", int'(ifa.stall), 1);
      chk("lw_wait_memread", int'(ifa.MemRead), 1);
      chk("lw_wait_regwrite", int'(ifa.RegWrite), 0);
    end
    ins(6'h23, 6'h00, 5'h00, 1'b1);
    chk("lw_done_regwrite", int'(ifa.RegWrite), 3);
    chk("lw_done_stall", int'(ifa.stall), 0);

    ins(6'h28, 6'h00, 5'h00, 1'b1);
    chk("sb_rd_memread", int'(ifa.MemRead), 1);
    chk("sb_rd_stall", int'(ifa.stall), 1);
    chk("sb_rd_memwrite", int'(ifa.MemWrite), 0);
    chk("sb_normmw_memwrite", int'(ifb.MemWrite), 1);
    chk("sb_normmw_stall", int'(ifb.stall), 0);
    ins(6'h28, 6'h00, 5'h00, 1'b1);
    chk("sb_wr_memwrite", int'(ifa.MemWrite), 1);
    chk("sb_wr_memread", int'(ifa.MemRead), 0);
    chk("sb_wr_stall", int'(ifa.stall), 0);

    ins(6'h29, 6'h00, 5'h00, 1'b0);
    ins(6'h29, 6'h00, 5'h00, 1'b1);
    ins(6'h29, 6'h00, 5'h00, 1'b0);
    chk("sh_wr_wait_stall", int'(ifa.stall), 1);
    ins(6'h29, 6'h00, 5'h00, 1'b1);
    chk("sh_wr_done_stall", int'(ifa.stall), 0);

    ins(6'h00, 6'h1A, 5'h00, 1'b0);
    chk("div_start", int'(ifa.muldiv_start), 1);
    chk("div_is_div", int'(ifa.muldiv_is_div), 1);
    stalls = 0;
    hi_last = 0;
    for (int i = 0; i < 100; i++) begin
      ins(6'h00, 6'h12, 5'h00, 1'b0);
      if (!ifa.stall) break;
      stalls++;
      hi_last = int'(ifa.HI_write);
    end
    chk("mflo_stall_cycles", stalls, 32);
    chk("div_hi_write_last", hi_last, 3);
    chk("mflo_memtoreg", int'(ifa.MemtoReg), 4);
    chk("mflo_regwrite", int'(ifa.RegWrite), 3);

    ins(6'h00, 6'h11, 5'h00, 1'b0);
    chk("mthi_hi_write", int'(ifa.HI_write), 3);
    chk("mthi_lo_write", int'(ifa.LO_write), 0);

    ins(6'h00, 6'h18, 5'h00, 1'b0);
    chk("mult_start", int'(ifa.muldiv_start), 1);
    chk("mult_is_div", int'(ifa.muldiv_is_div), 0);
    ins(6'h00, 6'h21, 5'h00, 1'b0);
    chk("addu1_stall", int'(ifa.stall), 0);
    chk("addu1_regwrite", int'(ifa.RegWrite), 3);
    chk("addu1_busy", int'(ifa.muldiv_busy), 1);
    ins(6'h00, 6'h21, 5'h00, 1'b0);
    chk("addu2_stall", int'(ifa.stall), 0);
    idle();
    chk("mult_t3_hi_write", int'(ifa.HI_write), 0);
    idle();
    chk("mult_t4_hi_write", int'(ifa.HI_write), 3);
    chk("mult_t4_lo_write", int'(ifa.LO_write), 3);
    idle();
    chk("mult_t5_busy", int'(ifa.muldiv_busy), 0);

    ins(6'h00, 6'h19, 5'h00, 1'b0);
    idle();
    step(1'b0, 1'b0, 6'h00, 6'h00, 5'h00, 1'b0);
    chk("mult_rst_outputs", int'(act_a), 0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("mult_abort_busy", int'(ifa.muldiv_busy), 0);
      chk("mult_abort_hi", int'(ifa.HI_write), 0);
    end

    ins(6'h01, 6'h00, 5'h11, 1'b0);
    chk("bgezal_regdst", int'(ifa.RegDst), 2);
    chk("bgezal_memtoreg", int'(ifa.MemtoReg), 2);
    chk("bgezal_regwrite", int'(ifa.RegWrite), 3);
    chk("bgezal_delay", int'(ifa.delay_early), 1);

    ins(6'h00, 6'h08, 5'h00, 1'b0);
    chk("jr_jr", int'(ifa.JR), 1);
    chk("jr_regwrite", int'(ifa.RegWrite), 0);
    chk("jr_delay", int'(ifa.delay_early), 1);

    ins(6'h02, 6'h00, 5'h00, 1'b0);
    chk("j_jump", int'(ifa.Jump), 1);
    ins(6'h09, 6'h00, 5'h00, 1'b0);
    chk("addiu_regwrite", int'(ifa.RegWrite), 3);
    chk("addiu_regdst", int'(ifa.RegDst), 0);

    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
